led_panel_bcm_driver: RTL



---
 rtl/led_panel_bcm_driver_if.sv | 19 +
 rtl/led_panel_bcm_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_panel_bcm_driver_if.sv
// led_panel_bcm_driver_if: host-side pixel write and buffer-swap port of the BCM panel driver.
//   wr_en    host -> driver  write wr_data to the back buffer at wr_addr
//   wr_addr  host -> driver  pixel address, row*COLS+col
//   wr_data  host -> driver  {R[BITS-1:0], G, B}
//   swap_req host -> driver  one-cycle request to swap buffers at the next frame wrap
//   swap_ack driver -> host  one-cycle pulse on the cycle after the swap happens
interface led_panel_bcm_driver_if #(
    parameter int AW = 7,
    parameter int DW = 6
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          swap_ack;

    modport master (output wr_en, wr_addr, wr_data, swap_req, input swap_ack);
    modport slave  (input wr_en, wr_addr, wr_data, swap_req, output swap_ack);
endinterface

// File: rtl/led_panel_bcm_driver.sv
// led_panel_bcm_driver: BCM scan driver for shift-register LED panels with a double-buffered frame store.
//   clk, reset   system clock, synchronous active-high reset
//   en           scan enable, sampled in IDLE and at the end of every row
//   host         write port into the back buffer plus swap request/acknowledge
//   red/green/blue  column data, valid for the whole cycle before sclk rises
//   sclk         column shift clock (panel samples on its rising edge)
//   latch        one-cycle latch pulse after a full row of one bit plane
//   blank        1 = LEDs off; low for BASE_TICKS<<plane cycles per plane
//   aclk, arst   row-advance pulse / row counter reset
//   row_addr     binary row select
//   frame_start  one-cycle pulse when scanning enters row 0
module led_panel_bcm_driver #(
    parameter int COLS       = 32,
    parameter int SCAN_ROWS  = 4,
    parameter int BITS       = 2,
    parameter int BASE_TICKS = 4,
    parameter int AW         = $clog2(SCAN_ROWS * COLS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    led_panel_bcm_driver_if.slave        host,
    output logic                         red,
    output logic                         green,
    output logic                         blue,
    output logic                         sclk,
    output logic                         latch,
    output logic                         blank,
    output logic                         aclk,
    output logic                         arst,
    output logic [$clog2(SCAN_ROWS)-1:0] row_addr,
    output logic                         frame_start
);
    localparam int DEPTH = SCAN_ROWS * COLS;
    localparam int DW    = 3 * BITS;
    localparam int RW    = $clog2(SCAN_ROWS);
    localparam int CLW   = COLS > 1 ? $clog2(COLS) : 1;
    localparam int PW    = BITS > 1 ? $clog2(BITS) : 1;
    localparam int CW    = $clog2((BASE_TICKS << (BITS - 1)) + 1);

    typedef enum logic [2:0] {IDLE, SETUP, CLK, LATCH, SHOW, OFF, NEXT} state_t;

    typedef struct packed {
        state_t         state;
        logic [CLW-1:0] col;
        logic [PW-1:0]  plane;
        logic [CW-1:0]  cnt;
        logic [RW-1:0]  row;
        logic           front;
        logic           pending;
        logic           red;
        logic           green;
        logic           blue;
        logic           sclk;
        logic           latch;
        logic           blank;
        logic           aclk;
        logic           arst;
        logic           swap_ack;
        logic           frame_start;
    } regs_t;

    regs_t r, n;

    logic [DW-1:0] mem [2][DEPTH];
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] pix;
    logic          last_plane;

    assign rd_addr    = AW'(r.row) * AW'(COLS) + AW'(r.col);
    assign pix        = mem[r.front][rd_addr];
    assign last_plane = r.plane == PW'(BITS - 1);

    // Host writes always land in the bank that is not being displayed.
    always_ff @(posedge clk) begin
        if (host.wr_en && 32'(host.wr_addr) < DEPTH)
            mem[~r.front][host.wr_addr] <= host.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r       <= '0;
            r.sclk  <= 1'b1;
            r.blank <= 1'b1;
            r.arst  <= 1'b1;
        end else begin
            r <= n;
        end
    end

    always_comb begin
        n             = r;
        n.latch       = 1'b0;
        n.aclk        = 1'b0;
        n.swap_ack    = 1'b0;
        n.frame_start = 1'b0;
        n.pending     = r.pending | host.swap_req;
        case (r.state)
            IDLE: if (en) begin
                n.arst        = 1'b0;
                n.frame_start = 1'b1;
                n.col         = CLW'(COLS - 1);
                n.plane       = '0;
                n.state       = SETUP;
            end
            SETUP: begin
                n.sclk  = 1'b0;
                n.arst  = 1'b0;
                n.red   = 1'(pix[DW-1 -: BITS] >> r.plane);
                n.green = 1'(pix[BITS +: BITS] >> r.plane);
                n.blue  = 1'(pix[0 +: BITS] >> r.plane);
                n.state = CLK;
            end
            CLK: begin
                n.sclk  = 1'b1;
                n.col   = r.col == '0 ? r.col : r.col - CLW'(1);
                n.state = r.col == '0 ? LATCH : SETUP;
            end
            LATCH: begin
                n.latch = 1'b1;
                n.cnt   = CW'(BASE_TICKS) << r.plane;
                n.state = SHOW;
            end
            SHOW: begin
                n.blank = 1'b0;
                n.cnt   = r.cnt - CW'(1);
                n.state = r.cnt == CW'(1) ? OFF : SHOW;
            end
            OFF: begin
                n.blank = 1'b1;
                n.col   = CLW'(COLS - 1);
                n.plane = last_plane ? r.plane : r.plane + PW'(1);
                n.state = last_plane ? NEXT : SETUP;
            end
            NEXT: begin
                n.plane = '0;
                n.col   = CLW'(COLS - 1);
                n.state = en ? SETUP : IDLE;
                if (r.row == RW'(SCAN_ROWS - 1)) begin
                    n.row         = '0;
                    n.arst        = 1'b1;
                    n.frame_start = 1'b1;
                    // A request arriving in this very cycle is already folded into n.pending.
                    if (n.pending) begin
                        n.front    = ~r.front;
                        n.pending  = 1'b0;
                        n.swap_ack = 1'b1;
                    end
                end else begin
                    n.row  = r.row + RW'(1);
                    n.aclk = 1'b1;
                end
            end
            default: n.state = IDLE;
        endcase
    end

    assign red           = r.red;
    assign green         = r.green;
    assign blue          = r.blue;
    assign sclk          = r.sclk;
    assign latch         = r.latch;
    assign blank         = r.blank;
    assign aclk          = r.aclk;
    assign arst          = r.arst;
    assign row_addr      = r.row;
    assign frame_start   = r.frame_start;
    assign host.swap_ack = r.swap_ack;
endmodule
